// File: rtl/sub_pkg.sv
// Shared types and defaults for the multi-operand subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_OPS = 16;

    // Width needed to hold an operand count of 0..max_ops inclusive.
    function automatic int cnt_w(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

endpackage

// File: rtl/sub_step.sv
// One combinational subtract step: d = a + ~b + 1 via a full-adder ripple chain.
module sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             co,
    output logic             c_msb
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_bn;

    assign w_bn   = ~b;
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign d[i]     = a[i] ^ w_bn[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & w_bn[i]) | (a[i] & w_c[i]) | (w_bn[i] & w_c[i]);
    end

    assign co    = w_c[WIDTH];
    assign c_msb = w_c[WIDTH-1];

endmodule

// File: rtl/multi_operand_sub8.sv
// Sequential multi-operand subtractor with sticky borrow/overflow flags.
// Optional build macro MULTI_OPERAND_SUB8_SATURATE_EN saturates acc on signed overflow.
module multi_operand_sub8
    import sub_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  MAX_OPS = DEF_MAX_OPS,
    localparam int CW      = cnt_w(MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [CW-1:0]    n_ops,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_co;
    logic             w_c_msb;
    logic             w_step_ovf;
    logic [CW-1:0]    w_n_clamp;

    sub_step #(.WIDTH(WIDTH)) u_step (
        .a    (r_acc),
        .b    (operand),
        .d    (w_d),
        .co   (w_co),
        .c_msb(w_c_msb)
    );

    assign w_step_ovf = w_co ^ w_c_msb;
    assign w_n_clamp  = (n_ops > MAX_CNT) ? MAX_CNT : n_ops;

`ifdef MULTI_OPERAND_SUB8_SATURATE_EN
    // Overflow direction follows the sign of the pre-step accumulator.
    always_comb begin
        w_acc_next = w_d;
        if (w_step_ovf)
            w_acc_next = r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign w_acc_next = w_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= minuend;
                        r_borrow <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= w_n_clamp;
                        r_busy   <= 1'b1;
                        if (w_n_clamp == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc    <= w_acc_next;
                        r_borrow <= r_borrow | ~w_co;
                        r_ovf    <= r_ovf | w_step_ovf;
                        r_cnt    <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A coincident start is dropped; it must be re-presented in IDLE.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_acc;
    assign borrow    = r_borrow;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_multi_operand_sub8.sv
// Directed self-checking bench for multi_operand_sub8 with a reference arithmetic model.
module tb_multi_operand_sub8;

    localparam int WIDTH = 8;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] minuend = '0;
    logic [CW-1:0]    n_ops = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] operand = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_errs   = 0;

    // Expected result of the transaction currently in flight.
    int exp_diff   = 0;
    int exp_borrow = 0;
    int exp_ovf    = 0;

    int ops[32];

    multi_operand_sub8 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .minuend  (minuend),
        .n_ops    (n_ops),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .operand  (operand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Plain integer model: unsigned borrow when acc < operand, signed overflow when
    // the true signed difference leaves [-128, 127].
    task automatic model(input int m, input int n);
        int acc, sa, so, s, k;
        bit br, ov;
        acc = m & 255;
        br = 0;
        ov = 0;
        k = (n > 16) ? 16 : n;
        for (int i = 0; i < k; i++) begin
            sa = (acc > 127) ? acc - 256 : acc;
            so = (ops[i] > 127) ? ops[i] - 256 : ops[i];
            s  = sa - so;
            if (acc < ops[i]) br = 1;
            if (s < -128 || s > 127) begin
                ov = 1;
`ifdef MULTI_OPERAND_SUB8_SATURATE_EN
                acc = (sa >= 0) ? 127 : 128;
`else
                acc = (acc - ops[i]) & 255;
`endif
            end else begin
                acc = (acc - ops[i]) & 255;
            end
        end
        exp_diff   = acc;
        exp_borrow = br;
        exp_ovf    = ov;
    endtask

    // Compare process: result and handshake sanity every cycle outputs are meaningful.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                chk("mon_diff",   int'(diff),   exp_diff);
                chk("mon_borrow", int'(borrow), exp_borrow);
                chk("mon_ovf",    int'(ovf),    exp_ovf);
                chk("mon_rdy_vs_vld", int'(in_ready), 0);
            end
            if (in_ready || out_valid)
                chk("mon_busy", int'(busy), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int m, input int n);
        model(m, n);
        minuend = WIDTH'(m);
        n_ops   = CW'(n);
        start   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed k operands from ops[], with `gap` idle cycles before each one.
    task automatic feed(input int k, input int gap);
        int waited;
        for (int i = 0; i < k; i++) begin
            repeat (gap) tick();
            operand  = WIDTH'(ops[i]);
            in_valid = 1'b1;
            waited = 0;
            while (!in_ready && waited < 20) begin
                tick();
                waited++;
            end
            if (!in_ready) chk("in_ready_timeout", 0, 1);
            tick();
            in_valid = 1'b0;
            if (i < k - 1) chk("early_out_valid", int'(out_valid), 0);
        end
    endtask

    task automatic finish_txn(input int hold, input bit pulse_start);
        for (int h = 0; h < hold; h++) begin
            if (pulse_start && h == 2) begin
                start   = 1'b1;
                minuend = 8'hAA;
                n_ops   = 5'd3;
            end
            tick();
            start = 1'b0;
            chk("hold_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_diff",      int'(diff),      0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        // 100 - 30 - 20 = 50
        ops[0] = 30; ops[1] = 20;
        do_start(100, 2);
        chk("t1_busy", int'(busy), 1);
        chk("t1_in_ready", int'(in_ready), 1);
        feed(2, 0);
        chk("t1_latency", int'(out_valid), 1);
        chk("t1_diff", int'(diff), 50);
        chk("t1_borrow", int'(borrow), 0);
        chk("t1_ovf", int'(ovf), 0);
        finish_txn(1, 0);

        // 5 - 10 = 0xFB with borrow
        ops[0] = 10;
        do_start(5, 1);
        feed(1, 1);
        chk("t2_diff", int'(diff), 8'hFB);
        chk("t2_borrow", int'(borrow), 1);
        chk("t2_ovf", int'(ovf), 0);
        finish_txn(0, 0);

        // -128 - 1 overflows
        ops[0] = 1;
        do_start(8'h80, 1);
        feed(1, 0);
`ifdef MULTI_OPERAND_SUB8_SATURATE_EN
        chk("t3_diff", int'(diff), 8'h80);
`else
        chk("t3_diff", int'(diff), 8'h7F);
`endif
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_borrow", int'(borrow), 0);
        finish_txn(0, 0);

        // zero operands: result the cycle after start
        do_start(8'h3C, 0);
        chk("t4_latency", int'(out_valid), 1);
        chk("t4_diff", int'(diff), 8'h3C);
        chk("t4_flags", int'({borrow, ovf}), 0);
        finish_txn(0, 0);

        // clamped count, gaps, stalled consumer with ignored start
        for (int i = 0; i < 32; i++) ops[i] = 1;
        do_start(8'h20, 20);
        feed(16, 1);
        chk("t5_latency", int'(out_valid), 1);
        chk("t5_diff", int'(diff), 8'h10);
        finish_txn(5, 1);
        tick();
        chk("t5_start_ignored", int'(busy), 0);

        // reset mid-accumulate
        ops[0] = 3; ops[1] = 4; ops[2] = 5; ops[3] = 6;
        do_start(8'h50, 4);
        feed(3, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_diff", int'(diff), 0);
        tick();
        rst = 1'b0;
        tick();
        ops[0] = 4;
        do_start(9, 1);
        feed(1, 2);
        chk("t6_diff", int'(diff), 5);
        finish_txn(0, 0);

        // mixed signs: 0x7F - 0xFF(-1) overflows, then -3 wraps back
        ops[0] = 8'hFF; ops[1] = 3;
        do_start(8'h7F, 2);
        feed(2, 0);
        chk("t7_ovf", int'(ovf), 1);
        chk("t7_borrow", int'(borrow), 1);
        finish_txn(2, 0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_operand_sub8.md
Name: multi_operand_sub8

Overview:
- Sequential multi-operand subtractor: loads a minuend, then subtracts a stream of N operands, one per accepted handshake, and returns the final difference.
- Reports sticky unsigned-borrow and signed-overflow flags.
- Serves as the inverse-direction companion to the ripple adder datapath in the multi-operand adder library.
- The per-step subtract is a + ~b + 1 through the same full-adder ripple structure. Signed overflow is carry-out XOR carry-into-MSB.

Parameters:
- WIDTH, 8, operand/result width in bits
- MAX_OPS, 16, maximum operand count per transaction; count port width CW = $clog2(MAX_OPS+1)

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a transaction; sampled only in IDLE
- minuend  input  WIDTH  initial accumulator value, latched on accepted start
- n_ops  input  CW  number of operands to subtract, latched on accepted start
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- operand  input  WIDTH  subtrahend, consumed when in_valid&&in_ready
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  final difference (two's complement, mod 2^WIDTH)
- borrow  output  1  sticky: some step had an unsigned borrow (carry-out == 0)
- ovf  output  1  sticky: some step had signed overflow
- busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = IDLE
  - acc, cnt, borrow, ovf = 0
  - in_ready, out_valid, busy = 0
  - Any transaction in progress is discarded; no partial result is emitted.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - On start: acc <= minuend; borrow, ovf <= 0; cnt <= min(n_ops, MAX_OPS).
  - Next state is DONE if the clamped count is 0, otherwise ACCUM.
- ACCUM:
  - in_ready = 1.
  - On in_valid: acc <= acc - operand; borrow |= ~co; ovf |= (co ^ c_msb); cnt <= cnt - 1.
  - If cnt == 1 at acceptance, next state is DONE.
  - in_valid low: the state holds with no change.
  - start is ignored.
- DONE:
  - out_valid = 1; diff = acc; borrow and ovf are driven from the sticky registers.
  - On out_ready: next state is IDLE and out_valid drops the next cycle.
  - out_valid, diff and flags stay stable while out_ready = 0.
  - start is ignored.
  - A start asserted in the same cycle as the out_ready handshake is not accepted. It must be re-presented in IDLE.
- Latency:
  - out_valid rises in the cycle after the last operand is accepted.
  - For n_ops = 0, out_valid rises in the cycle after start.
  - Throughput is one operand per clock.
- Registered-output timing: in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.
- Arithmetic wraps modulo 2^WIDTH. Flags never clear within a transaction.

Optional Feature:
- Macro: MULTI_OPERAND_SUB8_SATURATE_EN.
- Defined: on any step with signed overflow, acc saturates instead of wrapping:
  - to 0x7F..F if the pre-step acc is non-negative
  - to 0x80..0 if the pre-step acc is negative
  - ovf is still set.
- Undefined: wrap-around result, as specified above.
- The borrow flag behaves identically in both builds.

Decomposition:
- Shared package sub_pkg holds:
  - the state enum typedef (IDLE, ACCUM, DONE)
  - the default WIDTH and MAX_OPS constants
  - a localparam function for CW.
- One sub-module, sub_step:
  - combinational WIDTH-bit subtract stage
  - inputs a, b; outputs d, co, c_msb
  - built as a full-adder ripple with inverted b and carry-in = 1.
- The top module holds only the FSM, counter, accumulator and flag registers.

Test Plan:
- minuend=100, n_ops=2, operands 30, 20 -> diff=50, borrow=0, ovf=0; out_valid the cycle after the 2nd accept.
- minuend=5, n_ops=1, operand 10 -> diff=0xFB, borrow=1, ovf=0.
- minuend=0x80, n_ops=1, operand 1:
  - default build -> diff=0x7F, ovf=1, borrow=0
  - SATURATE_EN build -> diff=0x80, ovf=1.
- n_ops=0, minuend=0x3C -> out_valid the cycle after start, diff=0x3C, flags 0.
- n_ops=20 (clamped to 16): feed operand 1 sixteen times with in_valid gaps from minuend 0x20 -> diff=0x10. Hold out_ready=0 for 5 cycles and pulse start meanwhile -> out_valid and diff stable, start ignored.
- Assert rst mid-ACCUM after 3 of 4 operands -> outputs zero immediately, busy=0. A new transaction (minuend=9, operand 4) -> diff=5.
